// File: rtl/aes_hmac_out_collector.sv
// Reassembles the byte-serial AES/HMAC result stream into cipher and tag words
// and presents each completed frame on a valid/ready handshake.
module aes_hmac_out_collector #(
    parameter int CIPHER_BYTES = 16,
    parameter int TAG_BYTES    = 32,
    parameter int GAP_MAX      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                i_data,
    input  logic                      i_valid,
    output logic [8*CIPHER_BYTES-1:0] o_cipher,
    output logic [8*TAG_BYTES-1:0]    o_tag,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_busy,
    output logic                      o_err,
    output logic                      o_ovf
);

    localparam int CNT_MAX = (CIPHER_BYTES > TAG_BYTES) ? CIPHER_BYTES : TAG_BYTES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GAP_W   = $clog2(GAP_MAX + 2);

    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(CIPHER_BYTES - 1);
    localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(TAG_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] G_LIM   = GAP_W'(GAP_MAX);
    localparam logic [GAP_W-1:0] G_ONE   = GAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CIPHER,
        S_GAP,
        S_TAG,
        S_HOLD
    } state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [GAP_W-1:0]          gap_q;
    logic [8*CIPHER_BYTES-1:0] cipher_q;
    logic [8*TAG_BYTES-1:0]    tag_q;
    logic                      valid_q;
    logic                      busy_q;
    logic                      err_q;
    logic                      ovf_q;
    logic                      in_frame;
    logic                      timeout;

    assign in_frame = (state_q == S_CIPHER) || (state_q == S_GAP) ||
                      (state_q == S_TAG);
    // Fires on the first idle cycle beyond the tolerated run.
    assign timeout  = in_frame && !i_valid && (gap_q == G_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            cipher_q <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (timeout) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                gap_q   <= '0;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (i_valid) begin
                            cipher_q[7:0] <= i_data;
                            cnt_q         <= CNT_ONE;
                            gap_q         <= '0;
                            busy_q        <= 1'b1;
                            state_q       <= S_CIPHER;
                        end
                    end
                    S_CIPHER: begin
                        if (i_valid) begin
                            cipher_q[8*int'(cnt_q) +: 8] <= i_data;
                            gap_q <= '0;
                            if (cnt_q == C_LAST) begin
                                cnt_q   <= '0;
                                state_q <= S_GAP;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end else begin
                            gap_q <= gap_q + G_ONE;
                        end
                    end
                    S_GAP: begin
                        if (i_valid) begin
                            tag_q[7:0] <= i_data;
                            cnt_q      <= CNT_ONE;
                            gap_q      <= '0;
                            state_q    <= S_TAG;
                        end else begin
                            gap_q <= gap_q + G_ONE;
                        end
                    end
                    S_TAG: begin
                        if (i_valid) begin
                            tag_q[8*int'(cnt_q) +: 8] <= i_data;
                            gap_q <= '0;
                            if (cnt_q == T_LAST) begin
                                cnt_q   <= '0;
                                valid_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_HOLD;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end else begin
                            gap_q <= gap_q + G_ONE;
                        end
                    end
                    S_HOLD: begin
                        if (i_ready) begin
                            valid_q <= 1'b0;
                            // A byte coincident with the handshake opens the next frame.
                            if (i_valid) begin
                                cipher_q[7:0] <= i_data;
                                cnt_q         <= CNT_ONE;
                                gap_q         <= '0;
                                busy_q        <= 1'b1;
                                state_q       <= S_CIPHER;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else if (i_valid) begin
                            ovf_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_cipher = cipher_q;
    assign o_tag    = tag_q;
    assign o_valid  = valid_q;
    assign o_busy   = busy_q;
    assign o_err    = err_q;
    assign o_ovf    = ovf_q;

endmodule

// File: doc/aes_hmac_out_collector.md
Name: aes_hmac_out_collector

Overview:
- Downstream stage of the AES/PBKDF2/HMAC top; consumes its byte-serial result stream (o_data/o_valid).
- Each frame is 16 ciphertext bytes, a gap of at least one idle cycle, then 32 HMAC tag bytes.
- Reassembles a frame into a 128-bit cipher word and a 256-bit tag word, then presents them on a valid/ready handshake to the system-side consumer.
- Flags framing violations: over-long gaps and bytes arriving while a completed frame is still unconsumed.

Parameters:
- CIPHER_BYTES, 16, bytes in cipher phase.
- TAG_BYTES, 32, bytes in tag phase.
- GAP_MAX, 4, max consecutive idle cycles tolerated inside a frame, including the cipher-to-tag gap.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- i_data  input  8  byte from upstream top (its o_data).
- i_valid  input  1  byte strobe from upstream top (its o_valid).
- o_cipher  output  128  assembled ciphertext.
- o_tag  output  256  assembled HMAC tag.
- o_valid  output  1  frame available.
- i_ready  input  1  consumer accepts frame.
- o_busy  output  1  frame assembly in progress.
- o_err  output  1  one-cycle pulse on gap timeout.
- o_ovf  output  1  sticky overflow flag, cleared only by reset.

Behaviour:
- Interface decisions:
  - Single clock clk.
  - Reset rst_n is synchronous and active-low.
  - While rst_n=0 at a clock edge, every output clears: o_cipher=0, o_tag=0, o_valid=0, o_busy=0, o_err=0, o_ovf=0; state=IDLE; byte counter and gap counter = 0.
  - Reset mid-frame discards the partial frame. No state survives.
- Byte placement:
  - k-th accepted byte of the cipher phase (k=0 first) is written to o_cipher[8k+7:8k].
  - k-th byte of the tag phase is written to o_tag[8k+7:8k].
  - This matches the upstream LSB-first rotate-out order.
  - Unwritten bits keep their previous values; every byte is overwritten each frame.
- States:
  - IDLE:
    - o_busy=0.
    - i_valid=1 writes byte 0 of the cipher, sets cnt=1, goes to CIPHER.
  - CIPHER:
    - o_busy=1.
    - i_valid=1 writes byte cnt, increments cnt, clears gap.
    - When byte CIPHER_BYTES-1 is written: cnt=0, go to GAP.
    - i_valid=0 increments gap.
  - GAP:
    - o_busy=1.
    - i_valid=0 increments gap.
    - i_valid=1 writes tag byte 0, sets cnt=1, clears gap, goes to TAG.
  - TAG:
    - Same as CIPHER, but writes o_tag.
    - After byte TAG_BYTES-1: go to HOLD; o_valid=1 from the next cycle.
  - HOLD:
    - o_valid=1, o_busy=0.
    - o_cipher and o_tag are stable.
    - When o_valid & i_ready: o_valid=0 next cycle and go to IDLE.
- Gap timeout:
  - Applies in CIPHER, GAP and TAG.
  - When gap would exceed GAP_MAX (i.e. the GAP_MAX+1-th consecutive idle cycle): o_err=1 for exactly one cycle, state→IDLE, counters cleared.
  - No o_valid for the aborted frame.
- Simultaneous events:
  - In HOLD with i_ready=1 and i_valid=1 in the same cycle: the handshake completes and the byte is taken as cipher byte 0 of the next frame (state→CIPHER, cnt=1). No overflow.
  - In HOLD with i_valid=1 and i_ready=0: the byte is dropped, o_ovf set (sticky), frame data is unchanged, and HOLD continues.
- Latency: o_valid rises 1 cycle after the last tag byte is sampled.
- o_valid stays asserted until i_ready. It never drops without a handshake except on reset.
- Counter widths: cnt is ceil(log2(max(CIPHER_BYTES,TAG_BYTES)+1)) bits; gap counter is ceil(log2(GAP_MAX+2)) bits. Neither counter wraps: both saturate or clear per the rules above.

Test Plan:
- Nominal frame: 16 valid bytes 0x00..0x0F, 1 idle cycle, 32 valid bytes 0x20..0x3F, i_ready=1.
  - Required: o_cipher=0x0F0E..0100, o_tag=0x3F3E..2120.
  - o_valid pulses exactly 1 cycle, 1 cycle after byte 0x3F.
  - o_err=0, o_ovf=0.
- Backpressure: same frame with i_ready=0 for 10 cycles, then 1.
  - Required: o_valid held 11 cycles with data stable.
  - Drop occurs the cycle after i_ready=1.
- Gap timeout: 16 cipher bytes then 5 idle cycles (GAP_MAX=4).
  - Required: o_err=1 on the 5th idle cycle only, back in IDLE.
  - A following full frame assembles correctly.
- Mid-cipher stall: i_valid low for 4 cycles after byte 7, then the frame completes.
  - Required: no o_err, bytes correctly placed.
- Overflow and back-to-back:
  - i_valid=1 in HOLD with i_ready=0 → o_ovf=1 sticky, data unchanged.
  - i_valid=1 in the same cycle as i_ready=1 → byte becomes o_cipher[7:0] of the next frame.
- Reset mid-TAG after 10 tag bytes, rst_n=0 for 1 cycle.
  - Required: all outputs 0 the next cycle.
  - The next full frame yields correct o_cipher/o_tag.
